flash_image_loader: RTL
=======================

Name: flash_image_loader

Overview:
Boot-time SPI flash master that copies one 64 KB ROM/RAM image from serial flash into sram64k before the CPU is released. It sits directly upstream of the RAM bus mux and drives the flash-side ram_* signals. When the copy finishes it asserts read_complete, which hands the RAM and SPI pins over to the CPU and diagnostics paths. The image is selected by the configuration value latched at the start of loading.

Parameters:
CLK_DIV, 2, clk cycles per spi_clk half-period (≥1)
CONFIG_BITS, 5, width of configuration input
FLASH_BASE, 24'h100000, flash byte address of image 0 (above bitstream)
IMAGE_BYTES, 65536, bytes copied per image (1..65536)
WAKE_DELAY, 1000, clk cycles with spi_cs high after release-from-power-down

Ports:
clk  in  1  system clock (SB_HFOSC)
reset  in  1  synchronous active-high reset
configuration  in  CONFIG_BITS  image select, sampled once
spi_clk  out  1  SPI clock, mode 0
spi_out  out  1  MOSI
spi_cs  out  1  flash chip select, active low
spi_miso  in  1  MISO
ram_address  out  16  RAM write address
ram_datain  out  8  RAM write data
ram_cs  out  1  RAM select, active high
ram_we  out  1  RAM write enable, active high
read_complete  out  1  image loaded; sticky until reset

Behaviour:
- Reset values: spi_clk=0, spi_out=0, spi_cs=1, ram_address=0, ram_datain=0, ram_cs=0, ram_we=0, read_complete=0; state=IDLE.
- Reset asserted in any state: all outputs return to reset values on the next clk edge; any SPI transaction is abandoned (cs high); loading restarts from IDLE.
- States: IDLE -> WAKE_CMD -> WAKE_WAIT -> READ_CMD -> READ_BYTE -> WRITE -> (READ_BYTE | DONE).
- IDLE: one cycle; latches configuration; computes flash_addr = (FLASH_BASE + (configuration << 16)) truncated to 24 bits.
- WAKE_CMD: spi_cs=0; shift 8'hAB MSB first; then spi_cs=1.
- WAKE_WAIT: spi_cs=1 for exactly WAKE_DELAY cycles.
- READ_CMD: spi_cs=0; shift 32 bits {8'h03, flash_addr}, MSB first. spi_cs stays low through DONE entry.
- SPI bit timing (mode 0): spi_out is updated while spi_clk is low. spi_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles. spi_miso is sampled on the clk edge at which spi_clk rises. One bit occupies 2*CLK_DIV cycles.
- READ_BYTE: 8 bit periods, spi_out=0, shift spi_miso into byte register MSB first.
- WRITE: exactly one cycle with ram_cs=1, ram_we=1, ram_address=byte index, ram_datain=received byte. spi_clk is held low during this cycle (a static pause is legal for SPI). ram_cs and ram_we are 0 in all other cycles.
- Byte index counter is 17 bits. It increments after each WRITE. When the count reaches IMAGE_BYTES, go to DONE; otherwise go to READ_BYTE. Index 16'hFFFF is the last address when IMAGE_BYTES=65536; the address never wraps.
- Per-byte cost: 16*CLK_DIV + 1 clk cycles.
- DONE: spi_cs=1, spi_clk=0, spi_out=0, ram_cs/ram_we=0, read_complete=1. read_complete rises on the cycle after the final WRITE. DONE persists until reset; configuration changes are ignored and no further SPI activity occurs.
- spi_cs is deasserted only while spi_clk=0. spi_clk never toggles while spi_cs=1.

Test Plan:
1. Reset release, CLK_DIV=2 -> spi_cs falls, MOSI carries 8'hAB over 8 periods of 4 clk each; spi_cs high for exactly 1000 cycles afterward.
2. configuration=5'd3, FLASH_BASE=24'h100000 -> read header on MOSI is 8'h03, 8'h13, 8'h00, 8'h00 with spi_cs continuously low.
3. Flash model returns addr[7:0]^addr[15:8] -> 65536 single-cycle writes at addresses 0..FFFF in order with matching data; each byte takes 33 cycles; read_complete=1 the cycle after the write to FFFF; spi_cs=1.
4. IMAGE_BYTES=4 -> exactly 4 writes (addresses 0..3), then DONE; no 5th spi_clk byte period.
5. Assert reset during byte 100, change configuration to 5'd7 -> next cycle all outputs at reset values; reload restarts with header 8'h03, 8'h17, 8'h00, 8'h00.
6. After DONE, toggle configuration and spi_miso for 10k cycles -> read_complete stays 1; spi_clk, spi_cs, ram_cs and ram_we never change.

Source files
------------

// File: rtl/flash_image_loader.sv
// Boot-time SPI flash master: wakes the flash, issues a READ at the image
// selected by configuration and streams the image into sram64k byte by byte.
// read_complete hands the RAM and SPI pins to the CPU side and stays set until reset.
module flash_image_loader #(
    parameter int          CLK_DIV     = 2,
    parameter int          CONFIG_BITS = 5,
    parameter logic [23:0] FLASH_BASE  = 24'h100000,
    parameter int          IMAGE_BYTES = 65536,
    parameter int          WAKE_DELAY  = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CONFIG_BITS-1:0] configuration,
    output logic                   spi_clk,
    output logic                   spi_out,
    output logic                   spi_cs,
    input  logic                   spi_miso,
    output logic [15:0]            ram_address,
    output logic [7:0]             ram_datain,
    output logic                   ram_cs,
    output logic                   ram_we,
    output logic                   read_complete
);

    localparam int              DIV_W     = $clog2(2*CLK_DIV+1);
    localparam int              WAIT_W    = $clog2(WAKE_DELAY+1);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV-1);   // last spi_clk-low cycle
    localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);     // first spi_clk-high cycle
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV-1); // last cycle of a bit
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAKE_DELAY-1);
    localparam logic [16:0]     LAST_IDX  = 17'(IMAGE_BYTES-1);

    typedef enum logic [2:0] {
        IDLE, WAKE_CMD, WAKE_WAIT, READ_CMD, READ_BYTE, WRITE, DONE
    } state_t;

    state_t              state, state_nxt;
    logic [DIV_W-1:0]    div_cnt;
    logic [4:0]          bit_cnt;
    logic [31:0]         tx_sr;
    logic [7:0]          rx_byte;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [16:0]         byte_idx;
    logic [23:0]         flash_addr;

    logic in_bit, bit_end, bit_last;

    assign in_bit   = (state == WAKE_CMD) || (state == READ_CMD) || (state == READ_BYTE);
    assign bit_end  = in_bit && (div_cnt == DIV_LAST);
    // Command header is 32 bits; wake command and data bytes are 8.
    assign bit_last = bit_end && (bit_cnt == ((state == READ_CMD) ? 5'd31 : 5'd7));

    assign ram_address = byte_idx[15:0];
    assign ram_datain  = rx_byte;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and pin decode; chip select only rises on spi_clk-low cycles
    always_comb begin
        state_nxt     = state;
        spi_clk       = 1'b0;
        spi_out       = 1'b0;
        spi_cs        = 1'b1;
        ram_cs        = 1'b0;
        ram_we        = 1'b0;
        read_complete = 1'b0;
        case (state)
            IDLE: state_nxt = WAKE_CMD;
            WAKE_CMD: begin
                spi_cs  = 1'b0;
                spi_clk = (div_cnt >= DIV_HIGH);
                spi_out = tx_sr[31];
                if (bit_last) state_nxt = WAKE_WAIT;
            end
            WAKE_WAIT: if (wait_cnt == WAIT_LAST) state_nxt = READ_CMD;
            READ_CMD: begin
                spi_cs  = 1'b0;
                spi_clk = (div_cnt >= DIV_HIGH);
                spi_out = tx_sr[31];
                if (bit_last) state_nxt = READ_BYTE;
            end
            READ_BYTE: begin
                spi_cs  = 1'b0;
                spi_clk = (div_cnt >= DIV_HIGH);
                if (bit_last) state_nxt = WRITE;
            end
            WRITE: begin
                // spi_clk parked low: a static pause between data bytes
                spi_cs    = 1'b0;
                ram_cs    = 1'b1;
                ram_we    = 1'b1;
                state_nxt = (byte_idx == LAST_IDX) ? DONE : READ_BYTE;
            end
            DONE: read_complete = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, shifters and byte/wake counters
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_byte    <= '0;
            wait_cnt   <= '0;
            byte_idx   <= '0;
            flash_addr <= '0;
        end else begin
            if (in_bit) div_cnt <= bit_end ? '0 : div_cnt + 1'b1;
            else        div_cnt <= '0;

            if (bit_last)     bit_cnt <= '0;
            else if (bit_end) bit_cnt <= bit_cnt + 5'd1;

            case (state)
                IDLE: begin
                    flash_addr <= FLASH_BASE + 24'({configuration, 16'h0000});
                    tx_sr      <= {8'hAB, 24'h000000};
                    wait_cnt   <= '0;
                end
                WAKE_CMD, READ_CMD: if (bit_end) tx_sr <= {tx_sr[30:0], 1'b0};
                WAKE_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    tx_sr    <= {8'h03, flash_addr};
                end
                // Sample MISO on the edge where spi_clk rises
                READ_BYTE: if (div_cnt == DIV_RISE) rx_byte <= {rx_byte[6:0], spi_miso};
                WRITE:     byte_idx <= byte_idx + 17'd1;
                default: ;
            endcase
        end
    end

endmodule
